// File: rtl/axi_lite_master_if.sv
// AXI-Lite channel bundle between the command-driven master and its SRAM subordinate.
interface axi_lite_master_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic                  aw_valid;
   logic                  aw_ready;
   logic [ADDR_W-1:0]     aw_addr;
   logic                  aw_prot;
   logic                  w_valid;
   logic                  w_ready;
   logic [DATA_W-1:0]     w_data;
   logic [DATA_W/8-1:0]   w_strb;
   logic                  b_valid;
   logic                  b_ready;
   logic [1:0]            b_resp;
   logic                  ar_valid;
   logic                  ar_ready;
   logic [ADDR_W-1:0]     ar_addr;
   logic                  ar_prot;
   logic                  r_valid;
   logic                  r_ready;
   logic [DATA_W-1:0]     r_data;
   logic [1:0]            r_resp;

   modport master (
      output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
             ar_valid, ar_addr, ar_prot, r_ready,
      input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );

   modport slave (
      input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
             ar_valid, ar_addr, ar_prot, r_ready,
      output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );
endinterface

// File: rtl/axi_lite_master.sv
// Command/response to AXI-Lite bridge: pipelined reads up to MAX_RD deep, single
// outstanding write, read and write phases never overlap so responses stay in order.
module axi_lite_master #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16,
   parameter int MAX_RD = 4,
   localparam int STRB_W = DATA_W / 8,
   localparam int CNT_W  = $clog2(MAX_RD + 1)
) (
   input  logic               a_clk,
   input  logic               a_rst,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic               cmd_we_i,
   input  logic [ADDR_W-1:0]  cmd_addr_i,
   input  logic [DATA_W-1:0]  cmd_wdata_i,
   input  logic [STRB_W-1:0]  cmd_strb_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic               rsp_we_o,
   output logic [DATA_W-1:0]  rsp_data_o,
   output logic [1:0]         rsp_resp_o,
   axi_lite_master_if.master  axi,
   output logic [CNT_W-1:0]   rd_cnt_o,
   output logic               proto_err_o
);
   logic               wr_busy_q,   wr_busy_d;
   logic               aw_valid_q,  aw_valid_d;
   logic               w_valid_q,   w_valid_d;
   logic               ar_valid_q,  ar_valid_d;
   logic [ADDR_W-1:0]  aw_addr_q,   aw_addr_d;
   logic [ADDR_W-1:0]  ar_addr_q,   ar_addr_d;
   logic [DATA_W-1:0]  w_data_q,    w_data_d;
   logic [STRB_W-1:0]  w_strb_q,    w_strb_d;
   logic [CNT_W-1:0]   rd_cnt_q,    rd_cnt_d;
   logic               proto_err_q, proto_err_d;

   logic rd_room, wr_clear, rd_acc, wr_acc;
   logic r_ready, b_ready, r_done, b_done, r_stray, b_stray;

   // Write needs the read side fully drained; a read only needs a free slot.
   always_comb begin
      rd_room     = rd_cnt_q < CNT_W'(MAX_RD);
      wr_clear    = (rd_cnt_q == '0) && !ar_valid_q;
      cmd_ready_o = !a_rst && !wr_busy_q && (!ar_valid_q || axi.ar_ready) &&
                    (cmd_we_i ? wr_clear : rd_room);
   end

   assign rd_acc = cmd_valid_i && cmd_ready_o && !cmd_we_i;
   assign wr_acc = cmd_valid_i && cmd_ready_o &&  cmd_we_i;

   always_comb begin
      rsp_valid_o = 1'b0;
      rsp_we_o    = 1'b0;
      rsp_data_o  = '0;
      rsp_resp_o  = '0;
      r_ready     = 1'b0;
      b_ready     = 1'b0;
      if (wr_busy_q) begin
         rsp_valid_o = axi.b_valid;
         rsp_we_o    = 1'b1;
         rsp_resp_o  = axi.b_resp;
         b_ready     = rsp_ready_i;
      end else begin
         rsp_valid_o = axi.r_valid && (rd_cnt_q != '0);
         rsp_data_o  = axi.r_data;
         rsp_resp_o  = axi.r_resp;
         // Beats nobody asked for are swallowed so the subordinate cannot wedge us.
         r_ready     = (rd_cnt_q == '0) ? 1'b1 : rsp_ready_i;
         b_ready     = 1'b1;
      end
   end

   assign r_done  = axi.r_valid && r_ready && (rd_cnt_q != '0);
   assign r_stray = axi.r_valid && !wr_busy_q && (rd_cnt_q == '0);
   assign b_done  = axi.b_valid && b_ready && wr_busy_q;
   assign b_stray = axi.b_valid && !wr_busy_q;

   always_comb begin
      ar_valid_d  = ar_valid_q;
      ar_addr_d   = ar_addr_q;
      aw_valid_d  = aw_valid_q;
      aw_addr_d   = aw_addr_q;
      w_valid_d   = w_valid_q;
      w_data_d    = w_data_q;
      w_strb_d    = w_strb_q;
      wr_busy_d   = wr_busy_q;
      rd_cnt_d    = rd_cnt_q + CNT_W'(rd_acc) - CNT_W'(r_done);
      proto_err_d = proto_err_q || r_stray || b_stray;

      if (rd_acc) begin
         ar_valid_d = 1'b1;
         ar_addr_d  = cmd_addr_i;
      end else if (axi.ar_ready) begin
         ar_valid_d = 1'b0;
      end

      if (wr_acc) begin
         wr_busy_d  = 1'b1;
         aw_valid_d = 1'b1;
         w_valid_d  = 1'b1;
         aw_addr_d  = cmd_addr_i;
         w_data_d   = cmd_wdata_i;
         w_strb_d   = cmd_strb_i;
      end else begin
         if (axi.aw_ready) aw_valid_d = 1'b0;
         if (axi.w_ready)  w_valid_d  = 1'b0;
         if (b_done)       wr_busy_d  = 1'b0;
      end
   end

   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         wr_busy_q   <= 1'b0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         aw_addr_q   <= '0;
         ar_addr_q   <= '0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         rd_cnt_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         wr_busy_q   <= wr_busy_d;
         aw_valid_q  <= aw_valid_d;
         w_valid_q   <= w_valid_d;
         ar_valid_q  <= ar_valid_d;
         aw_addr_q   <= aw_addr_d;
         ar_addr_q   <= ar_addr_d;
         w_data_q    <= w_data_d;
         w_strb_q    <= w_strb_d;
         rd_cnt_q    <= rd_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign axi.aw_valid = aw_valid_q;
   assign axi.aw_addr  = aw_addr_q;
   assign axi.aw_prot  = 1'b0;
   assign axi.w_valid  = w_valid_q;
   assign axi.w_data   = w_data_q;
   assign axi.w_strb   = w_strb_q;
   assign axi.b_ready  = b_ready;
   assign axi.ar_valid = ar_valid_q;
   assign axi.ar_addr  = ar_addr_q;
   assign axi.ar_prot  = 1'b0;
   assign axi.r_ready  = r_ready;

   assign rd_cnt_o    = rd_cnt_q;
   assign proto_err_o = proto_err_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: small SRAM subordinate model with tunable ready delays and
// read latency, scoreboard of expected responses checked by an independent monitor.
module tb_axi_lite_master;
   logic        a_clk = 1'b0;
   logic        a_rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [17:0] cmd_addr = '0;
   logic [15:0] cmd_wdata = '0;
   logic [1:0]  cmd_strb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_we;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic [2:0]  rd_cnt;
   logic        proto_err;

   axi_lite_master_if #(.ADDR_W(18), .DATA_W(16)) axi ();

   axi_lite_master #(.ADDR_W(18), .DATA_W(16), .MAX_RD(4)) dut (
      .a_clk       (a_clk),
      .a_rst       (a_rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .cmd_strb_i  (cmd_strb),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_we_o    (rsp_we),
      .rsp_data_o  (rsp_data),
      .rsp_resp_o  (rsp_resp),
      .axi         (axi),
      .rd_cnt_o    (rd_cnt),
      .proto_err_o (proto_err)
   );

   always #5 a_clk = ~a_clk;

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   // ---------------- subordinate model ----------------
   typedef struct { logic [15:0] d; int t; } rent_t;
   rent_t       rq[$];
   logic [15:0] mem [0:63];
   int cyc = 0, aw_dly = 0, w_dly = 0, rd_lat = 1;
   bit ar_en = 1'b1;
   int inj_req = 0, inj_done = 0;
   int aw_wait, w_wait, mdl_rd_out;
   bit aw_got, w_got, aw_hold, w_hold, first_r_seen;
   logic [5:0]  wa;
   logic [15:0] wd, w_hold_data;
   logic [1:0]  ws;
   logic [17:0] last_aw, aw_hold_addr;
   logic [15:0] last_wd;
   logic [1:0]  last_ws;
   int aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, ar_before_r = -1;
   int aw_hs_cyc = 0, w_hs_cyc = 0, aw_unstable = 0, w_unstable = 0;

   initial for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);

   always @(posedge a_clk) begin
      cyc++;
      if (a_rst) begin
         axi.aw_ready <= 1'b0; axi.w_ready <= 1'b0; axi.b_valid <= 1'b0; axi.b_resp <= 2'b00;
         axi.ar_ready <= 1'b0; axi.r_valid <= 1'b0; axi.r_data <= '0; axi.r_resp <= 2'b00;
         rq.delete();
         aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; mdl_rd_out = 0;
         aw_hold = 0; w_hold = 0;
      end else begin
         if (aw_hold && (axi.aw_valid !== 1'b1 || axi.aw_addr !== aw_hold_addr)) aw_unstable++;
         if (w_hold && (axi.w_valid !== 1'b1 || axi.w_data !== w_hold_data)) w_unstable++;
         aw_hold = axi.aw_valid && !axi.aw_ready;
         aw_hold_addr = axi.aw_addr;
         w_hold = axi.w_valid && !axi.w_ready;
         w_hold_data = axi.w_data;

         if (axi.aw_valid && axi.aw_ready) begin
            aw_got = 1; wa = axi.aw_addr[5:0]; last_aw = axi.aw_addr;
            aw_beats++; aw_hs_cyc = cyc; aw_wait = 0; axi.aw_ready <= 1'b0;
         end else if (axi.aw_valid && !aw_got) begin
            if (aw_wait >= aw_dly) axi.aw_ready <= 1'b1; else aw_wait++;
         end
         if (axi.w_valid && axi.w_ready) begin
            w_got = 1; wd = axi.w_data; ws = axi.w_strb; last_wd = axi.w_data; last_ws = axi.w_strb;
            w_beats++; w_hs_cyc = cyc; w_wait = 0; axi.w_ready <= 1'b0;
         end else if (axi.w_valid && !w_got) begin
            if (w_wait >= w_dly) axi.w_ready <= 1'b1; else w_wait++;
         end
         if (axi.b_valid && axi.b_ready) begin
            axi.b_valid <= 1'b0; b_beats++;
         end else if (aw_got && w_got && !axi.b_valid) begin
            if (ws[0]) mem[wa][7:0]  = wd[7:0];
            if (ws[1]) mem[wa][15:8] = wd[15:8];
            axi.b_valid <= 1'b1; axi.b_resp <= 2'b00; aw_got = 0; w_got = 0;
         end

         if (axi.r_valid && axi.r_ready) begin
            rq.delete(0);
            if (mdl_rd_out > 0) mdl_rd_out--;
         end
         if (!first_r_seen && axi.r_valid) begin
            first_r_seen = 1; ar_before_r = ar_beats;
         end
         if (axi.ar_valid && axi.ar_ready) begin
            rq.push_back('{d: mem[axi.ar_addr[5:0]], t: cyc + rd_lat});
            ar_beats++; mdl_rd_out++;
         end
         if (inj_req != inj_done) begin
            rq.push_back('{d: 16'hDEAD, t: cyc});
            inj_done++;
         end
         axi.ar_ready <= ar_en;
         if (rq.size() > 0 && rq[0].t <= cyc) begin
            axi.r_valid <= 1'b1; axi.r_data <= rq[0].d; axi.r_resp <= 2'b00;
         end else begin
            axi.r_valid <= 1'b0;
         end
      end
   end

   // ---------------- scoreboard and monitor ----------------
   typedef struct packed { logic we; logic [15:0] d; logic [1:0] r; } exp_t;
   exp_t sb[$];
   int rd_peak = 0, overlap_err = 0;

   initial forever begin
      @(negedge a_clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected: got we=%0b data=0x%0h resp=%0d with nothing expected",
                     rsp_we, rsp_data, rsp_resp);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp", 32'({rsp_we, rsp_data, rsp_resp}), 32'(e));
         end
      end
      if (a_rst === 1'b0 && int'(rd_cnt) > rd_peak) rd_peak = int'(rd_cnt);
      if (a_rst === 1'b0 && axi.aw_valid === 1'b1 && (axi.ar_valid === 1'b1 || mdl_rd_out != 0))
         overlap_err++;
   end

   task automatic send(input bit we, input logic [17:0] a, input logic [15:0] d,
                       input logic [1:0] s, input logic [15:0] ed);
      int n = 0;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
      while (n < 300) begin
         @(negedge a_clk);
         if (cmd_ready) break;
         n++;
      end
      chk("cmd_accept", 32'(cmd_ready), 32'd1);
      if (cmd_ready) sb.push_back('{we: we, d: (we ? 16'h0000 : ed), r: 2'b00});
      @(posedge a_clk); #1;
      cmd_valid = 1'b0; cmd_we = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge a_clk);
         n++;
      end
      chk(name, 32'(sb.size()), 32'd0);
      @(posedge a_clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int  n;
      bit  seen, done;

      repeat (3) @(posedge a_clk);
      @(negedge a_clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_valids", 32'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 32'd0);
      chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
      @(posedge a_clk); #1;
      a_rst = 1'b0;
      @(negedge a_clk);
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge a_clk); #1;

      // single write
      aw_dly = 2; w_dly = 2;
      send(1'b1, 18'h00012, 16'hBEEF, 2'b11, 16'h0000);
      n = 0; seen = 0; done = 0;
      while (!done && n < 60) begin
         @(negedge a_clk);
         if (cmd_ready) seen = 1;
         if (axi.b_valid && axi.b_ready) done = 1;
         n++;
      end
      chk("wr_b_handshake", 32'(done), 32'd1);
      chk("wr_cmd_ready_low", 32'(seen), 32'd0);
      @(negedge a_clk);
      chk("wr_cmd_ready_after_b", 32'(cmd_ready), 32'd1);
      wait_drain("wr_drain");
      chk("wr_aw_beats", 32'(aw_beats), 32'd1);
      chk("wr_w_beats", 32'(w_beats), 32'd1);
      chk("wr_aw_addr", 32'(last_aw), 32'h12);
      chk("wr_w_data", 32'({last_ws, last_wd}), 32'h3BEEF);

      // pipelined reads
      aw_dly = 0; w_dly = 0; rd_lat = 4;
      for (int i = 0; i < 6; i++) send(1'b0, 18'(i), 16'h0, 2'b00, 16'h1000 + 16'(i));
      wait_drain("rd_drain");
      chk("rd_ar_before_r_le4", 32'(ar_before_r <= 4 && ar_before_r >= 1), 32'd1);
      chk("rd_peak", 32'(rd_peak), 32'd4);
      chk("rd_ar_beats", 32'(ar_beats), 32'd6);
      @(negedge a_clk);
      chk("rd_cnt_end", 32'(rd_cnt), 32'd0);
      @(posedge a_clk); #1;

      // ordering read / write / read
      rd_lat = 2;
      send(1'b0, 18'h10, 16'h0, 2'b00, 16'h1010);
      send(1'b1, 18'h10, 16'h5A5A, 2'b11, 16'h0000);
      send(1'b0, 18'h10, 16'h0, 2'b00, 16'h5A5A);
      wait_drain("ord_drain");
      chk("ord_no_overlap", 32'(overlap_err), 32'd0);

      // response backpressure
      rsp_ready = 1'b0;
      send(1'b0, 18'h3, 16'h0, 2'b00, 16'h1003);
      n = 0;
      while (axi.r_valid !== 1'b1 && n < 50) begin
         @(negedge a_clk);
         n++;
      end
      chk("bp_r_valid", 32'(axi.r_valid), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge a_clk);
         chk("bp_r_ready", 32'(axi.r_ready), 32'd0);
         chk("bp_rd_cnt", 32'(rd_cnt), 32'd1);
      end
      @(posedge a_clk); #1;
      rsp_ready = 1'b1;
      wait_drain("bp_drain");
      @(negedge a_clk);
      chk("bp_rd_cnt_end", 32'(rd_cnt), 32'd0);
      @(posedge a_clk); #1;

      // W handshake ahead of AW, low byte strobe only
      aw_dly = 3; w_dly = 0;
      send(1'b1, 18'h20, 16'h1234, 2'b01, 16'h0000);
      wait_drain("split_drain");
      chk("split_w_first", 32'(w_hs_cyc + 3 <= aw_hs_cyc), 32'd1);
      chk("split_aw_beats", 32'(aw_beats), 32'd3);
      chk("split_b_beats", 32'(b_beats), 32'd3);
      chk("split_aw_addr", 32'(last_aw), 32'h20);
      chk("split_hold", 32'(aw_unstable + w_unstable), 32'd0);
      aw_dly = 0;
      send(1'b0, 18'h20, 16'h0, 2'b00, 16'h1034);
      wait_drain("strb_drain");

      // unsolicited R beat
      inj_req++;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge a_clk);
         if (rsp_valid) seen = 1;
      end
      chk("unsol_proto_err", 32'(proto_err), 32'd1);
      chk("unsol_no_rsp", 32'(seen), 32'd0);
      chk("unsol_consumed", 32'(rq.size()), 32'd0);
      @(posedge a_clk); #1;

      // reset during an outstanding write
      aw_dly = 20; w_dly = 20;
      send(1'b1, 18'h30, 16'hAAAA, 2'b11, 16'h0000);
      repeat (2) @(posedge a_clk);
      @(negedge a_clk);
      chk("mid_aw_valid", 32'(axi.aw_valid), 32'd1);
      @(posedge a_clk); #1;
      a_rst = 1'b1;
      sb.delete();
      @(posedge a_clk); #1;
      a_rst = 1'b0;
      @(negedge a_clk);
      chk("mid_rst_valids", 32'({axi.aw_valid, axi.w_valid, axi.ar_valid, rsp_valid}), 32'd0);
      chk("mid_rst_rd_cnt", 32'(rd_cnt), 32'd0);
      chk("mid_rst_proto_err", 32'(proto_err), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge a_clk); #1;
      aw_dly = 0; w_dly = 0;
      send(1'b0, 18'h12, 16'h0, 2'b00, 16'hBEEF);
      wait_drain("final_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-initiator AXI-Lite master that turns a simple command/response stream into AW/W/B/AR/R channel traffic for the 18-bit-address, 16-bit-data SRAM AXI subordinate. It sits between an internal requester, such as a debug/UART command decoder or a test engine, and the SRAM bridge. Reads are pipelined up to MAX_RD outstanding. Writes are issued one at a time. Read and write phases never overlap, so responses come back in command order.

## Interface
- ADDR_W, 18, address width of cmd and AXI address channels
- DATA_W, 16, data width
- MAX_RD, 4, maximum outstanding reads (1..7)
- a_clk  in  1  clock; all logic is on the rising edge
- a_rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_we  out  1  1 = write response (B), 0 = read data (R)
- rsp_data  out  DATA_W  r_data for reads, 0 for writes
- rsp_resp  out  2  r_resp or b_resp
- aw_valid/aw_ready/aw_addr[ADDR_W]/aw_prot[1]  AXI write address channel, master side
- w_valid/w_ready/w_data[DATA_W]/w_strb[DATA_W/8]  AXI write data channel, master side
- b_valid/b_ready/b_resp[2]  AXI write response channel, master side
- ar_valid/ar_ready/ar_addr[ADDR_W]/ar_prot[1]  AXI read address channel, master side
- r_valid/r_ready/r_data[DATA_W]/r_resp[2]  AXI read data channel, master side
- rd_cnt  out  clog2(MAX_RD+1)  reads accepted whose R beat has not yet completed
- proto_err  out  1  sticky flag set on an unsolicited B or R beat

## Operation
- Reset values: aw_valid, w_valid, ar_valid, wr_busy, rd_cnt and proto_err are 0; address, data and strobe registers are 0. aw_prot and ar_prot are tied to 0.
- cmd_ready is combinational and is the AND of:
  - !a_rst
  - !wr_busy
  - (!ar_valid | ar_ready)
  - for a read: rd_cnt < MAX_RD
  - for a write: rd_cnt == 0 and !ar_valid
- cmd_ready depends on cmd_we; this is allowed on the internal port only.
- Read accept (cmd_valid & cmd_ready & !cmd_we):
  - ar_addr <= cmd_addr, ar_valid <= 1
  - rd_cnt increments
- ar_valid clears on the ar_valid & ar_ready edge unless a new read is accepted on the same edge. ar_addr stays stable while ar_valid is high.
- Write accept:
  - wr_busy <= 1, aw_valid <= 1, w_valid <= 1
  - aw_addr, w_data and w_strb are latched
- aw_valid and w_valid drop independently on their own handshakes, so AW-first, W-first and simultaneous handshakes are all legal.
- wr_busy clears on the b_valid & b_ready edge. Until then, aw_valid and w_valid never re-assert.
- Response mux, zero latency:
  - When wr_busy: rsp_valid = b_valid, rsp_we = 1, b_ready = rsp_ready, r_ready = 0.
  - Otherwise: rsp_valid = r_valid & (rd_cnt != 0), rsp_we = 0, r_ready = rsp_ready.
- rd_cnt decrements on an r_valid & r_ready edge. If a read is accepted and an R beat completes on the same edge, rd_cnt is unchanged.
- Unsolicited beats:
  - r_valid while rd_cnt == 0 and !wr_busy: r_ready = 1, the beat is dropped, proto_err <= 1.
  - b_valid while !wr_busy: b_ready = 1, the beat is dropped, proto_err <= 1.
  - proto_err clears only on reset.
- Reset mid-transaction abandons all state. Every valid deasserts at the reset edge. The subordinate must be reset with the master.

## Timing
- Read accepted at edge N: ar_valid is high from N+1. The earliest response is the cycle the subordinate first raises r_valid; it is forwarded in the same cycle.
- Back-to-back reads are accepted every cycle while ar_ready is high and rd_cnt < MAX_RD.
- Write accepted at edge N: aw_valid and w_valid are high from N+1. The next command of either kind is accepted no earlier than the cycle after the B handshake.
- Read→write turnaround: the write is held off until rd_cnt == 0 and ar_valid == 0.
- Write→read turnaround: the read is held off until wr_busy == 0.
- A valid never drops without its ready; the AXI valid-hold rule holds on AW, W and AR.

## Test plan
- Single write: cmd_we=1, addr=0x00012, data=0xBEEF, strb=2'b11, subordinate ready after 2 cycles → one AW and one W beat carrying exactly those values; rsp_valid with rsp_we=1, rsp_resp=0; cmd_ready low from the accept until after the B handshake.
- Pipelined reads: 6 read commands to addr 0..5 back-to-back, subordinate returns data 0x1000+addr with 4-cycle latency → at most 4 AR beats before the first R; rd_cnt peaks at 4; six responses 0x1000..0x1005 in order; rd_cnt ends at 0.
- Ordering: read(0x10), write(0x10, 0x5A5A), read(0x10) → the write's AW is not issued until the first R completes; response order R, B, R; final read returns 0x5A5A.
- Backpressure: rsp_ready held low 10 cycles with an R beat pending → r_ready=0 for those cycles, rd_cnt unchanged; the beat is delivered unchanged when rsp_ready rises.
- Split W/AW: subordinate asserts w_ready 3 cycles before aw_ready → w_valid drops first; aw_valid holds with a stable address; a single B beat completes the write.
- Unsolicited beat / reset: inject r_valid when idle → proto_err=1, the beat is consumed, no rsp_valid; then assert a_rst during an outstanding write → all valids 0 and rd_cnt=0 the next cycle; proto_err cleared.
